// File: rtl/keypoint_counter.sv
// Passive keypoint counter: monitors the detector-to-descriptor valid/ready link and
// latches the per-frame handshake count (saturating) for the threshold adapter.
module keypoint_counter #(
    parameter int unsigned CNT_W     = 11,
    parameter int unsigned RESET_NUM = 750
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic             frame_end,
    input  logic             kp_valid,
    input  logic             kp_ready,
    output logic [CNT_W-1:0] keypoint_num,
    output logic             kp_overflow,
    output logic             frame_done,
    output logic             frame_abort,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    localparam int unsigned FCNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_LATCH = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                sat_q, sat_d;
    logic [CNT_W-1:0]    num_q, num_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;
    logic                abort_q, abort_d;
    logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
    logic                hs;

    assign hs = kp_valid & kp_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; frame_end wins over frame_start while counting
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (frame_start) state_d = S_COUNT;
            S_COUNT: if (frame_end)   state_d = S_LATCH;
            S_LATCH: state_d = frame_start ? S_COUNT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next-values
    always_comb begin
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        num_d   = num_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        abort_d = 1'b0;
        fcnt_d  = fcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    cnt_d = '0;
                    sat_d = 1'b0;
                end
            end
            S_COUNT: begin
                if (frame_start && !frame_end) begin
                    // Restart: a coincident handshake is the first keypoint of the new frame
                    cnt_d   = CNT_W'(hs);
                    sat_d   = 1'b0;
                    abort_d = 1'b1;
                end else if (hs) begin
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_q >= CNT_MAX - CNT_W'(1)) begin
                        sat_d = 1'b1;
                    end
                end
            end
            S_LATCH: begin
                num_d  = cnt_q;
                ovf_d  = sat_q;
                done_d = 1'b1;
                fcnt_d = fcnt_q + FCNT_W'(1);
                if (frame_start) begin
                    cnt_d = '0;
                    sat_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            num_q   <= CNT_W'(RESET_NUM);
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            num_q   <= num_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            abort_q <= abort_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign keypoint_num = num_q;
    assign kp_overflow  = ovf_q;
    assign frame_done   = done_q;
    assign frame_abort  = abort_q;
    assign frame_cnt    = fcnt_q;
    assign busy         = (state_q == S_COUNT) || (state_q == S_LATCH);

endmodule
